// File: rtl/otter_intr_pkg.sv
// Shared definitions for the OTTER interrupt controller.
//   - intr_state_t : sequencing FSM state encoding
//   - *_OFS        : register byte offsets from the block base address
//   - cause_word() : packs the CAUSE register read value
package otter_intr_pkg;

    typedef enum logic [1:0] {IDLE, FIRE, WAIT_ACK, GAP} intr_state_t;

    localparam logic [31:0] ENABLE_OFS  = 32'd0;
    localparam logic [31:0] PENDING_OFS = 32'd4;
    localparam logic [31:0] CAUSE_OFS   = 32'd8;

    localparam int CAUSE_VALID_BIT = 31;

    function automatic logic [31:0] cause_word(input logic valid, input logic [2:0] id);
        logic [31:0] w;
        w = 32'd0;
        w[CAUSE_VALID_BIT] = valid;
        w[2:0] = id;
        return w;
    endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// Fixed-priority encoder: the lowest-index asserted request wins.
// Ports:
//   i_req : request vector
//   o_id  : index of the winning request (0 when none)
//   o_any : 1 when any request is asserted
module intr_prio_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_req,
    output logic [2:0]   o_id,
    output logic         o_any
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        o_id  = 3'd0;
        o_any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_any = 1'b1;
                o_id  = 3'(i);
            end
        end
    end

endmodule

// File: rtl/otter_intr_ctrl.sv
// Memory-mapped interrupt controller sharing the single OTTER_MCU INTR line
// between N_SRC rising-edge sources. Edges latch into PENDING, are masked by
// ENABLE, and the lowest-index request fires a PULSE_LEN-cycle INTR pulse.
// The controller then waits for software to clear (or disable) the source
// before a one-cycle gap and the next service.
//
// Ports:
//   CLK, RST    : clock, synchronous active-high reset
//   src_in      : raw interrupt source lines
//   IOBUS_ADDR  : MCU I/O address
//   IOBUS_OUT   : MCU write data
//   IOBUS_WR    : MCU write strobe
//   rd_data     : combinational read data for the mapped registers
//   rd_hit      : 1 when IOBUS_ADDR selects one of the three registers
//   INTR        : registered interrupt request to the MCU
//
// state    | meaning
// IDLE     | no interrupt in service, waiting for an enabled pending source
// FIRE     | INTR held high, counting down the pulse
// WAIT_ACK | pulse done, waiting for the serviced source to be cleared/disabled
// GAP      | one forced low cycle before the next interrupt may start
module otter_intr_ctrl
    import otter_intr_pkg::*;
#(
    parameter int          N_SRC     = 4,
    parameter logic [31:0] BASE_ADDR = 32'h1100E000,
    parameter int          PULSE_LEN = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_SRC-1:0] src_in,
    input  logic [31:0]      IOBUS_ADDR,
    input  logic [31:0]      IOBUS_OUT,
    input  logic             IOBUS_WR,
    output logic [31:0]      rd_data,
    output logic             rd_hit,
    output logic             INTR
);

    logic [N_SRC-1:0] r_enable;
    logic [N_SRC-1:0] r_pending;
    logic [N_SRC-1:0] r_src_prev;
    logic             r_cause_valid;
    logic [2:0]       r_cause_id;
    intr_state_t      r_state;
    logic [3:0]       r_cnt;
    logic             r_intr;

    logic [N_SRC-1:0] w_edge;
    logic [N_SRC-1:0] w_req;
    logic [N_SRC-1:0] w_w1c;
    logic [N_SRC-1:0] w_svc_mask;
    logic             w_svc_active;
    logic [2:0]       w_sel_id;
    logic             w_sel_any;
    logic             w_hit_en;
    logic             w_hit_pend;
    logic             w_hit_cause;
    logic             w_unused_iobus;

    assign w_hit_en    = (IOBUS_ADDR == BASE_ADDR + ENABLE_OFS);
    assign w_hit_pend  = (IOBUS_ADDR == BASE_ADDR + PENDING_OFS);
    assign w_hit_cause = (IOBUS_ADDR == BASE_ADDR + CAUSE_OFS);
    assign rd_hit      = w_hit_en | w_hit_pend | w_hit_cause;

    // Only the low N_SRC bits of write data carry register content.
    assign w_unused_iobus = ^IOBUS_OUT[31:N_SRC];

    assign w_edge = src_in & ~r_src_prev;
    assign w_req  = r_pending & r_enable;
    assign w_w1c  = (IOBUS_WR && w_hit_pend) ? IOBUS_OUT[N_SRC-1:0] : '0;

    intr_prio_enc #(.N(N_SRC)) u_prio (
        .i_req (w_req),
        .o_id  (w_sel_id),
        .o_any (w_sel_any)
    );

    // One-hot of the in-service source; avoids indexing with a 3-bit id
    // into a vector that may be narrower than 8 bits.
    always_comb begin
        w_svc_mask = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (r_cause_id == 3'(i)) begin
                w_svc_mask[i] = 1'b1;
            end
        end
    end

    assign w_svc_active = |(w_req & w_svc_mask);

    always_comb begin
        rd_data = 32'd0;
        if (w_hit_en) begin
            rd_data[N_SRC-1:0] = r_enable;
        end else if (w_hit_pend) begin
            rd_data[N_SRC-1:0] = r_pending;
        end else if (w_hit_cause) begin
            rd_data = cause_word(r_cause_valid, r_cause_id);
        end
    end

    // src_prev tracks src_in even during reset so a line already high at
    // release does not look like a fresh edge.
    always_ff @(posedge CLK) begin
        r_src_prev <= src_in;
        if (RST) begin
            r_enable  <= '0;
            r_pending <= '0;
        end else begin
            if (IOBUS_WR && w_hit_en) begin
                r_enable <= IOBUS_OUT[N_SRC-1:0];
            end
            // Set after clear: an edge coinciding with a W1C is kept.
            r_pending <= (r_pending & ~w_w1c) | w_edge;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= IDLE;
            r_cnt         <= 4'd0;
            r_intr        <= 1'b0;
            r_cause_valid <= 1'b0;
            r_cause_id    <= 3'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_intr <= 1'b0;
                    if (w_sel_any) begin
                        r_cause_valid <= 1'b1;
                        r_cause_id    <= w_sel_id;
                        r_cnt         <= 4'(PULSE_LEN - 1);
                        r_intr        <= 1'b1;
                        r_state       <= FIRE;
                    end
                end
                FIRE: begin
                    if (r_cnt == 4'd0) begin
                        r_intr  <= 1'b0;
                        r_state <= WAIT_ACK;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                WAIT_ACK: begin
                    r_intr <= 1'b0;
                    if (!w_svc_active) begin
                        r_cause_valid <= 1'b0;
                        r_state       <= GAP;
                    end
                end
                GAP: begin
                    r_intr  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_intr  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign INTR = r_intr;

endmodule

// File: tb/tb_otter_intr_ctrl.sv
// Bench for otter_intr_ctrl: register-access vector table, directed corner
// sequences, then randomized traffic against a behavioural model.
module tb_otter_intr_ctrl;

    localparam int          N    = 4;
    localparam logic [31:0] BASE = 32'h1100E000;
    localparam int          PL   = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  src_in = 4'd0;
    logic [31:0] IOBUS_ADDR = 32'd0;
    logic [31:0] IOBUS_OUT = 32'd0;
    logic        IOBUS_WR = 1'b0;
    logic [31:0] rd_data;
    logic        rd_hit;
    logic        INTR;

    otter_intr_ctrl #(.N_SRC(N), .BASE_ADDR(BASE), .PULSE_LEN(PL)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .src_in     (src_in),
        .IOBUS_ADDR (IOBUS_ADDR),
        .IOBUS_OUT  (IOBUS_OUT),
        .IOBUS_WR   (IOBUS_WR),
        .rd_data    (rd_data),
        .rd_hit     (rd_hit),
        .INTR       (INTR)
    );

    always #10 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Behavioural model: pulse cycles left, an "awaiting ack" flag and a
    // one-cycle gap flag describe the service progress.
    logic [3:0] m_prev = 4'd0;
    logic [3:0] m_pend = 4'd0;
    logic [3:0] m_en   = 4'd0;
    logic       m_valid = 1'b0;
    int         m_id   = 0;
    int         m_left = 0;
    bit         m_gap  = 1'b0;

    task automatic model_edge();
        logic [3:0] req;
        logic [3:0] w1c;
        if (RST) begin
            m_pend = 0; m_en = 0; m_valid = 0; m_id = 0; m_left = 0; m_gap = 0;
            m_prev = src_in;
            return;
        end
        req = m_pend & m_en;
        if (m_left > 0) begin
            m_left--;
        end else if (m_valid) begin
            if (!(m_pend[m_id] && m_en[m_id])) begin
                m_valid = 0;
                m_gap   = 1;
            end
        end else if (m_gap) begin
            m_gap = 0;
        end else if (req != 0) begin
            for (int i = N - 1; i >= 0; i--) if (req[i]) m_id = i;
            m_valid = 1;
            m_left  = PL;
        end
        w1c = (IOBUS_WR && IOBUS_ADDR == BASE + 4) ? IOBUS_OUT[3:0] : 4'd0;
        if (IOBUS_WR && IOBUS_ADDR == BASE) m_en = IOBUS_OUT[3:0];
        m_pend = (m_pend & ~w1c) | (src_in & ~m_prev);
        m_prev = src_in;
    endtask

    function automatic logic [32:0] m_read(input logic [31:0] a);
        if (a == BASE)     return {1'b1, 28'd0, m_en};
        if (a == BASE + 4) return {1'b1, 28'd0, m_pend};
        if (a == BASE + 8) return {1'b1, m_valid, 28'd0, 3'(m_id)};
        return 33'd0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic io_wr(input logic [31:0] a, input logic [31:0] d);
        IOBUS_ADDR = a; IOBUS_OUT = d; IOBUS_WR = 1'b1;
        step();
        IOBUS_WR = 1'b0; IOBUS_ADDR = 32'd0; IOBUS_OUT = 32'd0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        logic [31:0] sv;
        sv = IOBUS_ADDR;
        IOBUS_ADDR = a;
        #1;
        d = rd_data;
        IOBUS_ADDR = sv;
    endtask

    task automatic expect_pulse(input int id, input string nm);
        int waited;
        int n;
        logic [31:0] d;
        waited = 0;
        while (!INTR && waited < 12) begin
            step();
            waited++;
        end
        chk({nm, "_rise"}, INTR, 1);
        rd(BASE + 8, d);
        chk({nm, "_cause"}, d, 32'h80000000 | 32'(id));
        n = 0;
        while (INTR && n < 20) begin
            n++;
            step();
        end
        chk({nm, "_len"}, n, PL);
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] raddr;
        logic        exp_hit;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl[9];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [32:0] r;
        int sel;

        tbl[0] = '{1'b1, BASE,      32'hFFFFFFFF, BASE,      1'b1, 32'h0000000F};
        tbl[1] = '{1'b1, BASE,      32'h0000000A, BASE,      1'b1, 32'h0000000A};
        tbl[2] = '{1'b0, 32'd0,     32'd0,        BASE + 8,  1'b1, 32'h00000000};
        tbl[3] = '{1'b1, BASE + 8,  32'hFFFFFFFF, BASE + 8,  1'b1, 32'h00000000};
        tbl[4] = '{1'b0, 32'd0,     32'd0,        BASE + 12, 1'b0, 32'h00000000};
        tbl[5] = '{1'b0, 32'd0,     32'd0,        BASE - 4,  1'b0, 32'h00000000};
        tbl[6] = '{1'b1, BASE + 4,  32'hFFFFFFFF, BASE + 4,  1'b1, 32'h00000000};
        tbl[7] = '{1'b1, BASE + 16, 32'h00000005, BASE,      1'b1, 32'h0000000A};
        tbl[8] = '{1'b1, BASE,      32'h00000000, BASE,      1'b1, 32'h00000000};

        // 1: reset with src 0 already high -> no edge afterwards
        RST = 1'b1; src_in = 4'b0001;
        step(); step();
        RST = 1'b0;
        chk("rst_intr", INTR, 0);
        rd(BASE, d);     chk("rst_enable", d, 0);
        rd(BASE + 4, d); chk("rst_pending", d, 0);
        rd(BASE + 8, d); chk("rst_cause", d, 0);
        for (int k = 0; k < 20; k++) begin
            step();
            chk("t1_intr", INTR, 0);
            rd(BASE + 4, d); chk("t1_pending", d, 0);
        end

        // register access table
        for (int k = 0; k < 9; k++) begin
            if (tbl[k].wr) io_wr(tbl[k].addr, tbl[k].data);
            IOBUS_ADDR = tbl[k].raddr;
            #1;
            chk($sformatf("tbl%0d_hit", k), rd_hit, tbl[k].exp_hit);
            chk($sformatf("tbl%0d_rd", k), rd_data, tbl[k].exp_rd);
            IOBUS_ADDR = 32'd0;
            chk($sformatf("tbl%0d_intr", k), INTR, 0);
        end
        src_in = 4'd0;
        step();

        // 2: single source, exact pulse timing, ack
        io_wr(BASE, 32'hF);
        src_in = 4'b0100;
        step();
        src_in = 4'd0;
        rd(BASE + 4, d); chk("t2_pending", d, 32'h4);
        chk("t2_intr_pre", INTR, 0);
        step();
        for (int k = 0; k < PL; k++) begin
            chk("t2_high", INTR, 1);
            if (k == 1) begin
                rd(BASE + 8, d); chk("t2_cause", d, 32'h80000002);
            end
            step();
        end
        chk("t2_low", INTR, 0);
        step(); step();
        chk("t2_wait_intr", INTR, 0);
        rd(BASE + 8, d); chk("t2_wait_cause", d, 32'h80000002);
        io_wr(BASE + 4, 32'h4);
        step();
        rd(BASE + 8, d); chk("t2_gap_valid", d[31], 0);
        chk("t2_gap_intr", INTR, 0);
        step();

        // 3: simultaneous edges, priority order
        src_in = 4'b1010;
        step();
        src_in = 4'd0;
        expect_pulse(1, "t3a");
        io_wr(BASE + 4, 32'h2);
        expect_pulse(3, "t3b");
        io_wr(BASE + 4, 32'h8);
        step(); step(); step();

        // 4: pending while disabled, fires one cycle after enabling
        io_wr(BASE, 32'h0);
        src_in = 4'b0001;
        step();
        src_in = 4'd0;
        rd(BASE + 4, d); chk("t4_pending", d, 32'h1);
        step(); step();
        chk("t4_masked", INTR, 0);
        io_wr(BASE, 32'h1);
        chk("t4_wr_edge", INTR, 0);
        step();
        chk("t4_rise", INTR, 1);
        for (int k = 1; k < PL; k++) begin
            step();
            chk("t4_high", INTR, 1);
        end
        step();
        chk("t4_low", INTR, 0);

        // 5: W1C colliding with a new edge in WAIT_ACK keeps the event
        IOBUS_ADDR = BASE + 4; IOBUS_OUT = 32'h1; IOBUS_WR = 1'b1; src_in = 4'b0001;
        step();
        IOBUS_WR = 1'b0; IOBUS_ADDR = 32'd0; IOBUS_OUT = 32'd0; src_in = 4'd0;
        rd(BASE + 4, d); chk("t5_pending", d, 32'h1);
        step(); step();
        chk("t5_hold_intr", INTR, 0);
        rd(BASE + 8, d); chk("t5_hold_cause", d, 32'h80000000);
        io_wr(BASE, 32'h0);
        step(); step(); step();
        io_wr(BASE, 32'h1);
        expect_pulse(0, "t5b");
        io_wr(BASE + 4, 32'h1);
        step(); step(); step();

        // 6: reset during the second FIRE cycle
        src_in = 4'b0001;
        step();
        step();
        chk("t6_fire1", INTR, 1);
        step();
        chk("t6_fire2", INTR, 1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk("t6_intr", INTR, 0);
        rd(BASE, d);     chk("t6_enable", d, 0);
        rd(BASE + 4, d); chk("t6_pending", d, 0);
        rd(BASE + 8, d); chk("t6_cause", d, 0);
        io_wr(BASE, 32'hF);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t6_quiet", INTR, 0);
        end
        src_in = 4'd0;
        step();
        src_in = 4'b0001;
        step();
        expect_pulse(0, "t6_after");
        io_wr(BASE + 4, 32'h1);
        src_in = 4'd0;
        step(); step(); step();

        // randomized traffic against the model
        RST = 1'b1;
        step();
        RST = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            src_in = src_in ^ (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
            sel = $urandom_range(0, 4);
            case (sel)
                0: IOBUS_ADDR = BASE;
                1: IOBUS_ADDR = BASE + 4;
                2: IOBUS_ADDR = BASE + 8;
                3: IOBUS_ADDR = BASE + 12;
                default: IOBUS_ADDR = $urandom;
            endcase
            IOBUS_OUT = $urandom;
            IOBUS_WR  = ($urandom_range(0, 3) == 0);
            #1;
            r = m_read(IOBUS_ADDR);
            chk("rnd_hit", rd_hit, r[32]);
            chk("rnd_rd", rd_data, r[31:0]);
            step();
            chk("rnd_intr", INTR, (m_left > 0));
        end
        IOBUS_WR = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/otter_intr_ctrl.md
Name: otter_intr_ctrl

Overview:
- Memory-mapped interrupt controller that shares the single OTTER_MCU INTR input between N_SRC interrupt sources, e.g. timer_counter tc_intr and a debounced button.
- Latches rising edges into pending bits, masks them with an enable register and selects the highest-priority source.
- Drives a fixed-length INTR pulse, then holds off until software acknowledges over the IOBUS.
- Sits in OTTER_Wrapper between the sources and my_otter.INTR; its registers are mapped on IOBUS at BASE_ADDR.

Parameters:
- N_SRC, 4, number of interrupt sources (1..8).
- BASE_ADDR, 32'h1100E000, IOBUS base address of the register block.
- PULSE_LEN, 4, number of CLK cycles INTR is held high per interrupt (1..15).

Ports:
- CLK  in  1  system clock (wrapper s_clk).
- RST  in  1  synchronous, active-high reset.
- src_in  in  N_SRC  raw source lines; a rising edge requests an interrupt.
- IOBUS_ADDR  in  32  MCU I/O address.
- IOBUS_OUT  in  32  MCU write data.
- IOBUS_WR  in  1  MCU write strobe.
- rd_data  out  32  read data; the wrapper input mux routes it to IOBUS_in when rd_hit=1.
- rd_hit  out  1  combinational; 1 when IOBUS_ADDR is one of the three register addresses.
- INTR  out  1  interrupt request to OTTER_MCU.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - ENABLE, PENDING, CAUSE and INTR go to 0; the FSM goes to IDLE; the pulse counter goes to 0.
  - The src_prev register loads src_in, so a source that is already high produces no edge after reset.
  - Reset mid-pulse or mid-wait aborts immediately: INTR is 0 on the next cycle.
- Register map (32-bit, offsets from BASE_ADDR):
  - +0 ENABLE: read/write, bits [N_SRC-1:0]; upper bits read 0.
  - +4 PENDING: read; a write clears every bit written as 1 (write-1-to-clear).
  - +8 CAUSE: read-only, {valid at bit 31, 28'b0, id[2:0]}. Writes are ignored.
- Reads are combinational from the current register state. Writes take effect at the CLK edge where IOBUS_WR=1 and the address matches. Unmapped addresses give rd_hit=0 and rd_data=0.
- Edge detection:
  - edge[i] = src_in[i] & ~src_prev[i]; src_prev updates every cycle.
  - edge[i]=1 sets PENDING[i] on the next edge, regardless of ENABLE.
  - If an edge and a W1C of the same bit land in the same cycle, the set wins and the event is not lost.
- Selection:
  - req = PENDING & ENABLE.
  - The lowest-index set bit has highest priority; the selection is fixed, not round-robin.
- FSM states: IDLE, FIRE, WAIT_ACK, GAP.
  - IDLE: if req != 0, latch CAUSE = {1, sel_id}, load cnt = PULSE_LEN-1, go to FIRE. INTR is 0.
  - FIRE: INTR = 1. If cnt == 0, go to WAIT_ACK; otherwise cnt decrements. INTR is high for exactly PULSE_LEN cycles, with the first high cycle one cycle after req becomes nonzero.
  - WAIT_ACK: INTR = 0. Stay until PENDING[CAUSE.id] == 0 or ENABLE[CAUSE.id] == 0, then go to GAP and clear CAUSE.valid.
  - GAP: INTR = 0 for one cycle, then go to IDLE. This guarantees a low cycle between back-to-back interrupts.
- While in FIRE or WAIT_ACK, other sources' pending bits keep accumulating and are serviced in priority order after GAP.
- If ENABLE is cleared for the in-service source during FIRE, the pulse completes, then the FSM goes to WAIT_ACK -> GAP.
- A repeated edge on a source that is already pending is absorbed; only one interrupt is raised.
- INTR is registered, with no combinational path from src_in or the IOBUS.

Decomposition:
- Package otter_intr_pkg holds:
  - typedef enum logic [1:0] {IDLE, FIRE, WAIT_ACK, GAP} intr_state_t;
  - register offset localparams ENABLE_OFS=0, PENDING_OFS=4, CAUSE_OFS=8;
  - CAUSE_VALID_BIT=31.
- One sub-module, intr_prio_enc (N_SRC-wide lowest-index priority encoder giving id and any). It is combinational and reusable.

Test Plan:
1. RST with src_in=4'b0001 held high, then release -> PENDING stays 0 and INTR stays 0 for 20 cycles.
2. ENABLE=4'hF, pulse src_in[2] 0->1 -> PENDING=4'b0100 next cycle; INTR high for exactly 4 cycles starting one cycle later; CAUSE reads 32'h80000002; write 4'b0100 to +4 -> GAP, CAUSE.valid=0.
3. Edges on src 1 and 3 in the same cycle, ENABLE=4'hF -> first CAUSE id=1; after the W1C of bit 1 and GAP, a second 4-cycle pulse with CAUSE id=3.
4. ENABLE=4'b0000, edge on src 0 -> PENDING[0]=1 and INTR=0; write ENABLE=4'b0001 -> INTR rises one cycle after the write edge.
5. While in WAIT_ACK for id 0, a W1C of bit 0 in the same cycle as a new src 0 edge -> PENDING[0] remains 1; after GAP a second interrupt with id 0.
6. Assert RST during the 2nd FIRE cycle -> INTR=0 the next cycle, all registers read 0, and the FSM is in IDLE.
